// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// sobel_pkg : shared defaults, arbiter state encoding and counter sizing
// Rev 1.0
// ============================================================================
package sobel_pkg;

  function automatic int cnt_width(input int pix);
    return $clog2(pix + 1);
  endfunction

  localparam int c_WIDTH  = 720;
  localparam int c_HEIGHT = 540;
  localparam int c_DWIDTH = 8;
  localparam int c_PIX    = c_WIDTH * c_HEIGHT;
  localparam int c_CNT_W  = cnt_width(c_PIX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sobel_pix_counter.sv
`default_nettype none
// ============================================================================
// sobel_pix_counter : saturating frame pixel counter; terminal marks the
// increment that lands on PIX.  Rev 1.0
// ============================================================================
module sobel_pix_counter
  import sobel_pkg::*;
#(
  parameter int PIX = c_PIX,
  parameter int CW  = c_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [CW-1:0] c_MAX  = CW'(PIX);
  localparam logic [CW-1:0] c_LAST = CW'(PIX - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign terminal = inc && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sobel_frame_arbiter.sv
`default_nettype none
// ============================================================================
// sobel_frame_arbiter : frame-granular round-robin share of one sobel engine
// between two streams. Optional SOBEL_ARB_STATS_EN adds frames0/frames1.
// Rev 1.0
// ============================================================================
module sobel_frame_arbiter
  import sobel_pkg::*;
#(
  parameter int WIDTH  = c_WIDTH,
  parameter int HEIGHT = c_HEIGHT,
  parameter int DWIDTH = c_DWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_empty,
  input  logic [DWIDTH-1:0] req0_dout,
  output logic              req0_rd_en,
  input  logic              req1_empty,
  input  logic [DWIDTH-1:0] req1_dout,
  output logic              req1_rd_en,
  input  logic              out0_full,
  output logic              out0_wr_en,
  output logic [DWIDTH-1:0] out0_din,
  input  logic              out1_full,
  output logic              out1_wr_en,
  output logic [DWIDTH-1:0] out1_din,
  input  logic              eng_rd_en,
  output logic [DWIDTH-1:0] eng_dout,
  output logic              eng_empty,
  input  logic              eng_wr_en,
  input  logic [DWIDTH-1:0] eng_din,
  output logic              eng_full,
  output logic              busy,
  output logic              owner
`ifdef SOBEL_ARB_STATS_EN
  ,
  output logic [15:0]       frames0,
  output logic [15:0]       frames1
`endif
);

  localparam int c_FPIX = WIDTH * HEIGHT;
  localparam int c_FCW  = cnt_width(c_FPIX);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_owner;
  logic       r_last;
  logic       w_cand_valid;
  logic       w_cand;
  logic       w_grant;
  logic       w_rd_acc;
  logic       w_wr_acc;
  logic       w_in_term;
  logic       w_out_term;
  logic       w_own_empty;
  logic       w_own_full;

  // On a tie the requester that did not finish the previous frame wins.
  assign w_cand_valid = ~req0_empty | ~req1_empty;
  assign w_cand       = (~req0_empty & ~req1_empty) ? ~r_last : req0_empty;
  assign w_grant      = (r_state == IDLE) & w_cand_valid;

  assign w_own_empty = r_owner ? req1_empty : req0_empty;
  assign w_own_full  = r_owner ? out1_full  : out0_full;
  assign w_rd_acc    = eng_rd_en & ~eng_empty;
  assign w_wr_acc    = eng_wr_en & ~eng_full;
  assign owner       = r_owner;

  sobel_pix_counter #(.PIX(c_FPIX), .CW(c_FCW)) u_in_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_grant),
    .inc      (w_rd_acc),
    .terminal (w_in_term)
  );

  sobel_pix_counter #(.PIX(c_FPIX), .CW(c_FCW)) u_out_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_grant),
    .inc      (w_wr_acc),
    .terminal (w_out_term)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_grant)    r_owner <= w_cand;
      if (w_out_term) r_last  <= r_owner;
    end
  end

  // An early final write while still ACTIVE also ends the frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cand_valid) w_next = ACTIVE;
      ACTIVE: begin
        if (w_out_term)     w_next = IDLE;
        else if (w_in_term) w_next = DRAIN;
      end
      DRAIN:   if (w_out_term) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    eng_dout   = '0;
    eng_empty  = 1'b1;
    eng_full   = 1'b1;
    req0_rd_en = 1'b0;
    req1_rd_en = 1'b0;
    out0_wr_en = 1'b0;
    out1_wr_en = 1'b0;
    out0_din   = '0;
    out1_din   = '0;
    busy       = 1'b0;
    if (r_state == ACTIVE) begin
      eng_dout   = r_owner ? req1_dout : req0_dout;
      eng_empty  = w_own_empty;
      req0_rd_en = ~r_owner & eng_rd_en & ~req0_empty;
      req1_rd_en =  r_owner & eng_rd_en & ~req1_empty;
    end
    if ((r_state == ACTIVE) || (r_state == DRAIN)) begin
      busy     = 1'b1;
      eng_full = w_own_full;
      if (r_owner) begin
        out1_din   = eng_din;
        out1_wr_en = eng_wr_en & ~out1_full;
      end else begin
        out0_din   = eng_din;
        out0_wr_en = eng_wr_en & ~out0_full;
      end
    end
  end

`ifdef SOBEL_ARB_STATS_EN
  logic [15:0] r_frames0;
  logic [15:0] r_frames1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frames0 <= '0;
      r_frames1 <= '0;
    end else if (w_out_term) begin
      if (r_owner) r_frames1 <= r_frames1 + 16'd1;
      else         r_frames0 <= r_frames0 + 16'd1;
    end
  end

  assign frames0 = r_frames0;
  assign frames1 = r_frames1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sobel_frame_arbiter : scoreboard bench with FIFO and echo-engine models
// Rev 1.0
// ============================================================================
module tb_sobel_frame_arbiter;

  localparam int P  = 12;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0_empty, req1_empty, req0_rd_en, req1_rd_en;
  logic [DW-1:0] req0_dout, req1_dout;
  logic          out0_full, out1_full, out0_wr_en, out1_wr_en;
  logic [DW-1:0] out0_din, out1_din;
  logic          eng_rd_en, eng_empty, eng_wr_en, eng_full;
  logic [DW-1:0] eng_dout, eng_din;
  logic          busy, owner;
`ifdef SOBEL_ARB_STATS_EN
  logic [15:0]   frames0, frames1;
`endif

  always #5 clock = ~clock;

  sobel_frame_arbiter #(.WIDTH(4), .HEIGHT(3), .DWIDTH(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_empty (req0_empty),
    .req0_dout  (req0_dout),
    .req0_rd_en (req0_rd_en),
    .req1_empty (req1_empty),
    .req1_dout  (req1_dout),
    .req1_rd_en (req1_rd_en),
    .out0_full  (out0_full),
    .out0_wr_en (out0_wr_en),
    .out0_din   (out0_din),
    .out1_full  (out1_full),
    .out1_wr_en (out1_wr_en),
    .out1_din   (out1_din),
    .eng_rd_en  (eng_rd_en),
    .eng_dout   (eng_dout),
    .eng_empty  (eng_empty),
    .eng_wr_en  (eng_wr_en),
    .eng_din    (eng_din),
    .eng_full   (eng_full),
    .busy       (busy),
`ifdef SOBEL_ARB_STATS_EN
    .frames0    (frames0),
    .frames1    (frames1),
`endif
    .owner      (owner)
  );

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic          exp_own[$];
  logic [DW-1:0] q0[$], q1[$], echo[$];
  bit            rd_on, wr_on, full0, full1;
  logic          cur_own;
  logic          prev_busy;
  int            n_chk, n_pass, cyc, rd_p, wr_p, last_wr_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // FIFO / engine models present new values one step after each rising edge.
  always @(posedge clock) begin
    #1;
    req0_empty = (q0.size() == 0);
    req0_dout  = (q0.size() != 0) ? q0[0] : '0;
    req1_empty = (q1.size() == 0);
    req1_dout  = (q1.size() != 0) ? q1[0] : '0;
    eng_rd_en  = rd_on;
    eng_wr_en  = wr_on && (echo.size() != 0);
    eng_din    = (echo.size() != 0) ? echo[0] : '0;
    out0_full  = full0;
    out1_full  = full1;
  end

  // Monitor: consumes handshakes and compares against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    logic [DW-1:0] front;
    cyc++;
    if (!reset) begin
      prev_busy = 1'b0;
      rd_p = 0;
      wr_p = 0;
    end else begin
      if (busy && !prev_busy) begin
        rd_p = 0;
        wr_p = 0;
        if (exp_own.size() == 0) begin
          n_chk++;
          $display("FAIL grant_owner: unexpected grant to %0d, none expected", owner);
        end else begin
          cur_own = exp_own.pop_front();
          chk("grant_owner", owner, cur_own);
        end
      end
      if (!busy && prev_busy) begin
        chk("frame_reads", rd_p, P);
        chk("frame_writes", wr_p, P);
        chk("release_latency", cyc - last_wr_cyc, 1);
      end
      prev_busy = busy;

      if (req0_rd_en || req1_rd_en || (eng_rd_en && !eng_empty))
        chk("rd_handshake", {req1_rd_en, req0_rd_en},
            (eng_rd_en && !eng_empty) ? (cur_own ? 2 : 1) : 0);
      if (eng_rd_en && !eng_empty) begin
        rd_p++;
        if (cur_own ? (q1.size() == 0) : (q0.size() == 0)) begin
          n_chk++;
          $display("FAIL eng_dout: read accepted from empty requester %0d", cur_own);
        end else begin
          front = cur_own ? q1[0] : q0[0];
          chk("eng_dout", eng_dout, front);
        end
        echo.push_back(eng_dout);
      end
      if (req0_rd_en && (q0.size() != 0)) void'(q0.pop_front());
      if (req1_rd_en && (q1.size() != 0)) void'(q1.pop_front());

      if (out0_wr_en || out1_wr_en || (eng_wr_en && !eng_full))
        chk("wr_handshake", {out1_wr_en, out0_wr_en},
            (eng_wr_en && !eng_full) ? (cur_own ? 2 : 1) : 0);
      if (eng_wr_en && !eng_full && (echo.size() != 0)) void'(echo.pop_front());
      if (out0_wr_en || out1_wr_en) begin
        wr_p++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL out_write: unexpected write data %0d/%0d", out0_din, out1_din);
        end else begin
          e = exp_q.pop_front();
          chk("out_chan", out1_wr_en, e.ch);
          chk("out_data", e.ch ? out1_din : out0_din, e.d);
          chk("nonowner_din", e.ch ? out0_din : out1_din, 0);
        end
      end
    end
  end

  task automatic load_frame(input logic ch, input logic [DW-1:0] base);
    exp_own.push_back(ch);
    for (int i = 0; i < P; i++) begin
      if (ch) q1.push_back(base + DW'(i));
      else    q0.push_back(base + DW'(i));
      exp_q.push_back({ch, base + DW'(i)});
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    q0.delete(); q1.delete(); echo.delete();
    exp_q.delete(); exp_own.delete();
    rd_on = 0; wr_on = 0; full0 = 0; full1 = 0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
  endtask

  task automatic wait_done(input string name, input int lim);
    int k;
    k = 0;
    while ((k < lim) && !((exp_q.size() == 0) && (exp_own.size() == 0) && !busy)) begin
      @(negedge clock);
      #2;
      k++;
    end
    if (k >= lim) begin
      n_chk++;
      $display("FAIL %s_timeout: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, w_hold;
    req0_empty = 1; req1_empty = 1; req0_dout = '0; req1_dout = '0;
    eng_rd_en = 0; eng_wr_en = 0; eng_din = '0; out0_full = 0; out1_full = 0;
    cur_own = 0; prev_busy = 0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_eng_empty", eng_empty, 1);
    chk("rst_eng_full", eng_full, 1);
    chk("rst_owner", owner, 0);
    chk("rst_strobes", {req0_rd_en, req1_rd_en, out0_wr_en, out1_wr_en}, 0);
    chk("rst_din", {out0_din, out1_din}, 0);
    @(posedge clock);
    #3 reset = 1'b1;

    // Single requester, engine echoes pixels 1..12
    load_frame(0, 8'd1);
    rd_on = 1; wr_on = 1;
    wait_done("single", 200);

    // Both requesters loaded from reset: grants alternate 0,1,0,1
    do_reset();
    load_frame(0, 8'h20);
    load_frame(1, 8'h40);
    load_frame(0, 8'h60);
    load_frame(1, 8'h80);
    rd_on = 1; wr_on = 1;
    wait_done("round_robin", 400);

    // Engine keeps reading past the frame end
    do_reset();
    load_frame(0, 8'hA0);
    for (int i = 0; i < 8; i++) q0.push_back(8'hF0 + DW'(i));
    rd_on = 1; wr_on = 0;
    repeat (20) @(negedge clock);
    #2;
    chk("overread_reads", rd_p, P);
    chk("overread_eng_empty", eng_empty, 1);
    chk("overread_busy", busy, 1);
    chk("overread_q0_left", q0.size(), 8);
    wr_on = 1;
    wait_done("overread", 200);

    // Output FIFO back-pressure mid-frame
    do_reset();
    load_frame(0, 8'h10);
    rd_on = 1; wr_on = 1;
    k = 0;
    do begin
      @(negedge clock);
      #2;
      k++;
    end while ((wr_p < 6) && (k < 100));
    w_hold = wr_p;
    full0 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #2;
      chk("stall_eng_full", eng_full, 1);
      chk("stall_wr_en", out0_wr_en, 0);
      chk("stall_writes", wr_p, w_hold);
    end
    full0 = 0;
    wait_done("stall", 200);

    // Reset mid-frame after 7 reads
    do_reset();
    load_frame(0, 8'hC0);
    rd_on = 1; wr_on = 0;
    k = 0;
    do begin
      @(negedge clock);
      #2;
      k++;
    end while ((rd_p < 7) && (k < 100));
    chk("abort_reads_before", rd_p, 7);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_eng_empty", eng_empty, 1);
    chk("abort_rd_en", req0_rd_en, 0);
    chk("abort_owner", owner, 0);
    do_reset();
    load_frame(0, 8'hD0);
    load_frame(1, 8'hE0);
    rd_on = 1; wr_on = 1;
    wait_done("after_abort", 300);

`ifdef SOBEL_ARB_STATS_EN
    do_reset();
    load_frame(0, 8'h01);
    load_frame(1, 8'h11);
    load_frame(0, 8'h21);
    load_frame(1, 8'h31);
    load_frame(0, 8'h41);
    rd_on = 1; wr_on = 1;
    wait_done("stats", 500);
    chk("frames0", frames0, 3);
    chk("frames1", frames1, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_frame_arbiter.md
# sobel_frame_arbiter

Frame-granularity round-robin arbiter that shares one sobel engine between two pixel streams. Sits between two requester FIFO pairs (input/output) and the engine's FIFO-style ports. It grants the engine to one requester for exactly one WIDTH×HEIGHT frame, routes that requester's input pixels in and the engine's gradient pixels back out, and re-arbitrates only after the last output pixel of the frame is written.

## Interface
- WIDTH, 720, pixels per line
- HEIGHT, 540, lines per frame
- DWIDTH, 8, pixel width (input and output)
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- req0_empty / req1_empty  in  1  requester input FIFO empty
- req0_dout / req1_dout  in  DWIDTH  requester input FIFO data
- req0_rd_en / req1_rd_en  out  1  requester input FIFO read
- out0_full / out1_full  in  1  requester output FIFO full
- out0_wr_en / out1_wr_en  out  1  requester output FIFO write
- out0_din / out1_din  out  DWIDTH  requester output FIFO data
- eng_rd_en  in  1  engine reads a pixel
- eng_dout  out  DWIDTH  pixel presented to engine
- eng_empty  out  1  no pixel available to engine
- eng_wr_en  in  1  engine writes a gradient pixel
- eng_din  in  DWIDTH  gradient pixel from engine
- eng_full  out  1  engine must not write
- busy  out  1  a frame is granted
- owner  out  1  index of granted requester (valid while busy)

## Operation
- PIX = WIDTH×HEIGHT; in_cnt and out_cnt are clog2(PIX+1) bits, unsigned, saturating at PIX.
- States: IDLE, ACTIVE, DRAIN.
- IDLE: eng_empty=1, eng_full=1, all rd_en/wr_en 0. Candidate = requester with empty=0; if both, the one ≠ last; if none, stay. On a candidate, register owner, clear counters, go to ACTIVE.
- ACTIVE: eng_dout=req[owner]_dout; eng_empty=req[owner]_empty; req[owner]_rd_en = eng_rd_en & ~req[owner]_empty (combinational pass-through). in_cnt increments on accepted read (eng_rd_en & ~eng_empty). When the accepted read makes in_cnt=PIX, go to DRAIN.
- DRAIN: eng_empty forced 1; further eng_rd_en ignored, no rd_en issued.
- Output path (ACTIVE and DRAIN): eng_full=out[owner]_full; out[owner]_din=eng_din; out[owner]_wr_en = eng_wr_en & ~out[owner]_full. out_cnt increments on accepted write. Accepted write making out_cnt=PIX: last←owner, go to IDLE. If that happens while still ACTIVE (engine fault), go to IDLE likewise.
- Non-owner rd_en/wr_en always 0; non-owner din driven 0.
- busy=1 in ACTIVE and DRAIN.

## Timing
- Reset values: state IDLE, owner 0, last 1 (req0 wins first tie), counters 0, busy 0, eng_empty 1, eng_full 1, all rd_en/wr_en/din 0.
- Grant latency: candidate seen in IDLE cycle N → ACTIVE, data path live, in cycle N+1.
- Data path zero latency: rd_en/wr_en, eng_dout, out_din combinational from engine/FIFO signals of the same cycle.
- Release: final output write in cycle M → IDLE in M+1; earliest next grant visible in M+2.
- Simultaneous last-input read and output write in one cycle: both counted.
- Reset low mid-frame: abandon frame, return to reset values; no partial-frame recovery.

## Configuration
- SOBEL_ARB_STATS_EN defined: adds outputs frames0, frames1 (16 bits each, wrap at 65535→0), incremented in the cycle a frame for that requester completes; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package sobel_pkg: WIDTH/HEIGHT/DWIDTH defaults, state enum (IDLE, ACTIVE, DRAIN), PIX constant and its counter width.
- One sub-module: sobel_pix_counter (clear, inc, saturate at PIX, terminal flag), instantiated for in_cnt and out_cnt.

## Test plan
Use WIDTH=4, HEIGHT=3 (PIX=12).
- Only req0 non-empty, engine echoes pixels 1..12 → owner=0, 12 req0_rd_en pulses, 12 out0_wr_en with data 1..12, busy falls after 12th write, out1_wr_en never 1.
- Both requesters non-empty from reset → frames granted 0,1,0,1; each busy period has exactly 12 reads and 12 writes.
- Engine asserts eng_rd_en for 14 cycles with req0 always non-empty → exactly 12 reads accepted, eng_empty=1 afterwards.
- out0_full held high for 5 cycles mid-frame → eng_full=1 for those cycles, no out0_wr_en, out_cnt unchanged, frame completes at 12.
- reset low after 7 reads → busy 0, counters 0, next grant goes to req0 and counts 12 fresh reads.
- With SOBEL_ARB_STATS_EN: after 3 req0 and 2 req1 frames → frames0=3, frames1=2.
